// File: rtl/sound_irq_ctrl_pkg.sv
// Shared constants for the sound command / interrupt block.
// Holds the M68K interrupt priority encodings, the default Z80 interrupt
// divider and the event index map used to address the edge-detector bank.
package sound_irq_ctrl_pkg;

    // M68K priority levels presented on m68k_ipl_n
    localparam logic [2:0] IPL_NONE = 3'b111;
    localparam logic [2:0] IPL_VBL  = 3'b110;

    // 4 MHz z80_cen / 512 gives roughly 7812 Hz
    localparam int IRQ_DIV_DEFAULT = 512;

    // Bit positions of each cross-CPU event in the edge-detector bank
    typedef enum logic [2:0] {
        EV_W = 3'd0,   // M68K write to the sound latch
        EV_A = 3'd1,   // M68K vblank interrupt acknowledge
        EV_R = 3'd2,   // Z80 read of the command byte
        EV_C = 3'd3,   // Z80 clear of the command latch
        EV_K = 3'd4,   // Z80 interrupt acknowledge cycle
        EV_V = 3'd5    // vblank rising edge
    } event_e;

    localparam int NUM_EVENTS = 6;

    // Priority level shown to the M68K for a given vblank pending state
    function automatic logic [2:0] ipl_of(input logic pending);
        return pending ? IPL_VBL : IPL_NONE;
    endfunction

endpackage

// File: rtl/edge_pulse.sv
// Registered rising-edge detector.
// The output is a one-cycle registered pulse. Detection is disarmed for the
// first cycle after reset so a level already high when reset releases is
// treated as history rather than as a new edge.
module edge_pulse (
    input  logic clk_sys,
    input  logic reset,
    input  logic i_level,
    output logic o_pulse
);

    logic r_level;
    logic r_armed;
    logic r_pulse;

    // Capture level history and emit a pulse on a low-to-high transition
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_level <= 1'b0;
            r_armed <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_level <= i_level;
            r_armed <= 1'b1;
            r_pulse <= i_level & ~r_level & r_armed;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/sound_irq_ctrl.sv
// Cross-CPU sound command and interrupt block.
// Holds the M68K->Z80 command byte, raises the M68K vblank interrupt until
// acknowledged, and raises a periodic Z80 interrupt held until the Z80
// acknowledge cycle. Every decoder select becomes a one-cycle event through
// its own edge_pulse instance.
// Optional build macro SND_LATCH_FIFO_EN turns the single command latch into
// a FIFO_DEPTH-entry queue (FIFO_DEPTH must be a power of two, at least 2).
module sound_irq_ctrl
    import sound_irq_ctrl_pkg::*;
#(
    parameter int IRQ_DIV    = IRQ_DIV_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       z80_cen,
    input  logic       vblank,
    input  logic       sound_latch_cs,
    input  logic       irq_ack_cs,
    input  logic       m68k_rw,
    input  logic       m68k_lds_n,
    input  logic [7:0] m68k_dout,
    output logic [2:0] m68k_ipl_n,
    input  logic       z80_latch_r_cs,
    input  logic       z80_latch_clr_cs,
    input  logic       IORQ_n,
    input  logic       M1_n,
    output logic [7:0] z80_din,
    output logic       z80_int_n,
    output logic       latch_full
);

    localparam int DIV_W = (IRQ_DIV > 1) ? $clog2(IRQ_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(IRQ_DIV - 1);

    // ------------------------------------------------------------------
    // Event generation
    // ------------------------------------------------------------------
    logic [NUM_EVENTS-1:0] w_qual;
    logic [NUM_EVENTS-1:0] w_ev;
    logic w_ev_w;
    logic w_ev_a;
    logic w_ev_r;
    logic w_ev_c;
    logic w_ev_k;
    logic w_ev_v;

    assign w_qual[EV_W] = sound_latch_cs & ~m68k_rw & ~m68k_lds_n;
    assign w_qual[EV_A] = irq_ack_cs;
    assign w_qual[EV_R] = z80_latch_r_cs;
    assign w_qual[EV_C] = z80_latch_clr_cs;
    assign w_qual[EV_K] = ~M1_n & ~IORQ_n;
    assign w_qual[EV_V] = vblank;

    for (genvar g = 0; g < NUM_EVENTS; g++) begin : g_edge
        edge_pulse u_edge (
            .clk_sys (clk_sys),
            .reset   (reset),
            .i_level (w_qual[g]),
            .o_pulse (w_ev[g])
        );
    end

    assign w_ev_w = w_ev[EV_W];
    assign w_ev_a = w_ev[EV_A];
    assign w_ev_r = w_ev[EV_R];
    assign w_ev_c = w_ev[EV_C];
    assign w_ev_k = w_ev[EV_K];
    assign w_ev_v = w_ev[EV_V];

    // ------------------------------------------------------------------
    // M68K vblank interrupt
    // ------------------------------------------------------------------
    logic       r_vbl_pend;
    logic [2:0] r_ipl_n;
    logic       w_vbl_pend_nxt;

    // Vblank sets pending, ack clears it; a coincident vblank wins
    always_comb begin
        w_vbl_pend_nxt = r_vbl_pend;
        if (w_ev_v) begin
            w_vbl_pend_nxt = 1'b1;
        end else if (w_ev_a) begin
            w_vbl_pend_nxt = 1'b0;
        end else begin
            w_vbl_pend_nxt = r_vbl_pend;
        end
    end

    // Register the pending flag together with its priority encoding
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_vbl_pend <= 1'b0;
            r_ipl_n    <= IPL_NONE;
        end else begin
            r_vbl_pend <= w_vbl_pend_nxt;
            r_ipl_n    <= ipl_of(w_vbl_pend_nxt);
        end
    end

    assign m68k_ipl_n = r_ipl_n;

    // ------------------------------------------------------------------
    // Z80 periodic interrupt
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_nxt;
    logic             w_tick;
    logic             r_z80_pend;
    logic             r_z80_int_n;
    logic             w_z80_pend_nxt;

    // Divider counts z80_cen pulses and ticks on the wrap to zero
    always_comb begin
        w_div_nxt = r_div;
        w_tick    = 1'b0;
        if (z80_cen) begin
            if (r_div == DIV_LAST) begin
                w_div_nxt = '0;
                w_tick    = 1'b1;
            end else begin
                w_div_nxt = r_div + DIV_W'(1);
                w_tick    = 1'b0;
            end
        end else begin
            w_div_nxt = r_div;
            w_tick    = 1'b0;
        end
    end

    // Tick sets pending (absorbed if already set); acknowledge clears unless a tick coincides
    always_comb begin
        w_z80_pend_nxt = r_z80_pend;
        if (w_tick) begin
            w_z80_pend_nxt = 1'b1;
        end else if (w_ev_k) begin
            w_z80_pend_nxt = 1'b0;
        end else begin
            w_z80_pend_nxt = r_z80_pend;
        end
    end

    // Register divider, pending flag and the active-low INT output
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_div       <= '0;
            r_z80_pend  <= 1'b0;
            r_z80_int_n <= 1'b1;
        end else begin
            r_div       <= w_div_nxt;
            r_z80_pend  <= w_z80_pend_nxt;
            r_z80_int_n <= ~w_z80_pend_nxt;
        end
    end

    assign z80_int_n = r_z80_int_n;

    // ------------------------------------------------------------------
    // Sound command storage
    // ------------------------------------------------------------------
`ifdef SND_LATCH_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_rd;
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W:0]   r_cnt;
    logic [7:0]       r_din;
    logic             r_full;

    logic             w_push;
    logic             w_pop;
    logic [PTR_W-1:0] w_wr_slot;
    logic [PTR_W-1:0] w_rd_nxt;
    logic [PTR_W-1:0] w_wr_nxt;
    logic [PTR_W:0]   w_cnt_nxt;
    logic [7:0]       w_head_nxt;

    // Queue control: clear flushes first, so a coincident write becomes the only entry
    always_comb begin
        w_pop     = ~w_ev_c & w_ev_r & (r_cnt != '0);
        w_push    = w_ev_w & (w_ev_c | (r_cnt != CNT_FULL) | w_pop);
        w_wr_slot = w_ev_c ? '0 : r_wr;
        w_rd_nxt  = r_rd;
        w_wr_nxt  = r_wr;
        w_cnt_nxt = r_cnt;
        if (w_ev_c) begin
            w_rd_nxt  = '0;
            w_wr_nxt  = w_push ? PTR_W'(1) : '0;
            w_cnt_nxt = w_push ? (PTR_W + 1)'(1) : '0;
        end else begin
            w_rd_nxt = w_pop  ? r_rd + PTR_W'(1) : r_rd;
            w_wr_nxt = w_push ? r_wr + PTR_W'(1) : r_wr;
            case ({w_push, w_pop})
                2'b10:   w_cnt_nxt = r_cnt + (PTR_W + 1)'(1);
                2'b01:   w_cnt_nxt = r_cnt - (PTR_W + 1)'(1);
                default: w_cnt_nxt = r_cnt;
            endcase
        end
    end

    // Byte the Z80 will see next: bypass the incoming write when it lands at the head
    always_comb begin
        w_head_nxt = 8'h00;
        if (w_cnt_nxt == '0) begin
            w_head_nxt = 8'h00;
        end else if (w_push && (w_wr_slot == w_rd_nxt)) begin
            w_head_nxt = m68k_dout;
        end else begin
            w_head_nxt = r_mem[w_rd_nxt];
        end
    end

    // Queue storage write port
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else if (w_push) begin
            r_mem[w_wr_slot] <= m68k_dout;
        end else begin
            r_mem <= r_mem;
        end
    end

    // Queue pointers, occupancy and registered outputs
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_rd   <= '0;
            r_wr   <= '0;
            r_cnt  <= '0;
            r_din  <= 8'h00;
            r_full <= 1'b0;
        end else begin
            r_rd   <= w_rd_nxt;
            r_wr   <= w_wr_nxt;
            r_cnt  <= w_cnt_nxt;
            r_din  <= w_head_nxt;
            r_full <= (w_cnt_nxt == CNT_FULL);
        end
    end

    assign z80_din    = r_din;
    assign latch_full = r_full;
`else
    logic [7:0] r_latch;
    logic       r_valid;
    logic       w_unused;

    // The Z80 read does not change a single latch, and the depth is meaningless here
    assign w_unused = w_ev_r | (FIFO_DEPTH == 0);

    // Single latch: write loads and marks valid, clear zeroes; write wins a tie
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_latch <= 8'h00;
            r_valid <= 1'b0;
        end else if (w_ev_w) begin
            r_latch <= m68k_dout;
            r_valid <= 1'b1;
        end else if (w_ev_c) begin
            r_latch <= 8'h00;
            r_valid <= 1'b0;
        end else begin
            r_latch <= r_latch;
            r_valid <= r_valid;
        end
    end

    assign z80_din    = r_latch;
    assign latch_full = r_valid;
`endif

endmodule

// File: tb/tb_sound_irq_ctrl.sv
// Self-checking bench for sound_irq_ctrl: directed scenarios plus a random
// run compared every cycle against a behavioural model of the event rules.
module tb_sound_irq_ctrl;

    localparam int DIV   = 8;
    localparam int DEPTH = 4;

    logic       clk_sys = 1'b0;
    logic       reset = 1'b1;
    logic       z80_cen = 1'b0;
    logic       vblank = 1'b0;
    logic       sound_latch_cs = 1'b0;
    logic       irq_ack_cs = 1'b0;
    logic       m68k_rw = 1'b1;
    logic       m68k_lds_n = 1'b1;
    logic [7:0] m68k_dout = 8'h00;
    logic       z80_latch_r_cs = 1'b0;
    logic       z80_latch_clr_cs = 1'b0;
    logic       IORQ_n = 1'b1;
    logic       M1_n = 1'b1;
    logic [2:0] m68k_ipl_n;
    logic [7:0] z80_din;
    logic       z80_int_n;
    logic       latch_full;

    int n_vec = 0;
    int n_err = 0;

    sound_irq_ctrl #(.IRQ_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk_sys          (clk_sys),
        .reset            (reset),
        .z80_cen          (z80_cen),
        .vblank           (vblank),
        .sound_latch_cs   (sound_latch_cs),
        .irq_ack_cs       (irq_ack_cs),
        .m68k_rw          (m68k_rw),
        .m68k_lds_n       (m68k_lds_n),
        .m68k_dout        (m68k_dout),
        .m68k_ipl_n       (m68k_ipl_n),
        .z80_latch_r_cs   (z80_latch_r_cs),
        .z80_latch_clr_cs (z80_latch_clr_cs),
        .IORQ_n           (IORQ_n),
        .M1_n             (M1_n),
        .z80_din          (z80_din),
        .z80_int_n        (z80_int_n),
        .latch_full       (latch_full)
    );

    always #5 clk_sys = ~clk_sys;

    // ---------------- behavioural model ----------------
`ifdef SND_LATCH_FIFO_EN
    logic [7:0] m_q[$];
`else
    logic [7:0] m_latch;
    logic       m_valid;
`endif
    logic       m_vpend;
    logic       m_zpend;
    int         m_div;
    logic [5:0] m_prev;   // qualifier levels seen at the previous edge
    logic [5:0] m_ev;     // events detected, taking effect at the next edge
    logic       m_arm;

    task automatic model_clear();
`ifdef SND_LATCH_FIFO_EN
        m_q.delete();
`else
        m_latch = 8'h00;
        m_valid = 1'b0;
`endif
        m_vpend = 1'b0;
        m_zpend = 1'b0;
        m_div   = 0;
        m_prev  = 6'd0;
        m_ev    = 6'd0;
        m_arm   = 1'b0;
    endtask

    function automatic logic [7:0] exp_din();
`ifdef SND_LATCH_FIFO_EN
        if (m_q.size() == 0) return 8'h00;
        return m_q[0];
`else
        return m_latch;
`endif
    endfunction

    function automatic logic exp_full();
`ifdef SND_LATCH_FIFO_EN
        return (m_q.size() == DEPTH);
`else
        return m_valid;
`endif
    endfunction

    // One clock: model follows the posedge, returns at the negedge for sampling/driving
    task automatic cycle();
        logic [5:0] q;
        bit tick;
        bit pop;
        bit push;
        @(posedge clk_sys);
        if (reset) begin
            model_clear();
        end else begin
`ifdef SND_LATCH_FIFO_EN
            if (m_ev[3]) begin
                m_q.delete();
                if (m_ev[0]) m_q.push_back(m68k_dout);
            end else begin
                pop  = m_ev[2] && (m_q.size() > 0);
                push = m_ev[0] && ((m_q.size() < DEPTH) || pop);
                if (pop) void'(m_q.pop_front());
                if (push) m_q.push_back(m68k_dout);
            end
`else
            pop  = 1'b0;
            push = 1'b0;
            if (m_ev[0]) begin
                m_latch = m68k_dout;
                m_valid = 1'b1;
            end else if (m_ev[3]) begin
                m_latch = 8'h00;
                m_valid = 1'b0;
            end
`endif
            tick = z80_cen && (m_div == DIV - 1);
            if (z80_cen) m_div = (m_div + 1) % DIV;
            if (tick) m_zpend = 1'b1;
            else if (m_ev[4]) m_zpend = 1'b0;
            if (m_ev[5]) m_vpend = 1'b1;
            else if (m_ev[1]) m_vpend = 1'b0;
            q = {vblank, ~M1_n & ~IORQ_n, z80_latch_clr_cs, z80_latch_r_cs,
                 irq_ack_cs, sound_latch_cs & ~m68k_rw & ~m68k_lds_n};
            m_ev   = q & ~m_prev & {6{m_arm}};
            m_prev = q;
            m_arm  = 1'b1;
        end
        @(negedge clk_sys);
    endtask

    task automatic m68k_write(input logic [7:0] d);
        sound_latch_cs = 1'b1; m68k_rw = 1'b0; m68k_lds_n = 1'b0; m68k_dout = d;
        cycle();
        sound_latch_cs = 1'b0; m68k_rw = 1'b1; m68k_lds_n = 1'b1;
        cycle();
    endtask

    task automatic z80_pulse(input bit rd, input bit clr);
        z80_latch_r_cs = rd; z80_latch_clr_cs = clr;
        cycle();
        z80_latch_r_cs = 1'b0; z80_latch_clr_cs = 1'b0;
        cycle();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        cycle();
        cycle();
        n_vec++;
        if (m68k_ipl_n !== 3'b111 || z80_int_n !== 1'b1 || z80_din !== 8'h00 || latch_full !== 1'b0) begin
            n_err++;
            $display("FAIL reset_values: got ipl=%b int_n=%b din=%h full=%b expected 111 1 00 0",
                     m68k_ipl_n, z80_int_n, z80_din, latch_full);
        end
        reset = 1'b0;
        cycle();
        cycle();
    endtask

    task automatic test_latch();
        sound_latch_cs = 1'b1; m68k_rw = 1'b0; m68k_lds_n = 1'b0; m68k_dout = 8'h5A;
        cycle();
        n_vec++;
        if (z80_din !== 8'h00) begin
            n_err++; $display("FAIL latch_early: got %h expected 00", z80_din);
        end
        cycle();
        n_vec++;
        if (z80_din !== 8'h5A) begin
            n_err++; $display("FAIL latch_load: got %h expected 5a", z80_din);
        end
        n_vec++;
        if (latch_full !== exp_full()) begin
            n_err++; $display("FAIL latch_full_set: got %b expected %b", latch_full, exp_full());
        end
        sound_latch_cs = 1'b0; m68k_rw = 1'b1; m68k_lds_n = 1'b1;
        z80_pulse(1'b0, 1'b1);
        n_vec++;
        if (z80_din !== 8'h00 || latch_full !== 1'b0) begin
            n_err++; $display("FAIL latch_clear: got din=%h full=%b expected 00 0", z80_din, latch_full);
        end
    endtask

    task automatic test_vblank();
        vblank = 1'b1;
        cycle();
        n_vec++;
        if (m68k_ipl_n !== 3'b111) begin
            n_err++; $display("FAIL vbl_latency: got %b expected 111", m68k_ipl_n);
        end
        cycle();
        n_vec++;
        if (m68k_ipl_n !== 3'b110) begin
            n_err++; $display("FAIL vbl_set: got %b expected 110", m68k_ipl_n);
        end
        irq_ack_cs = 1'b1; cycle(); irq_ack_cs = 1'b0; cycle();
        n_vec++;
        if (m68k_ipl_n !== 3'b111) begin
            n_err++; $display("FAIL vbl_ack: got %b expected 111", m68k_ipl_n);
        end
        vblank = 1'b0; cycle();
        vblank = 1'b1; irq_ack_cs = 1'b1; cycle();
        irq_ack_cs = 1'b0; cycle();
        n_vec++;
        if (m68k_ipl_n !== 3'b110) begin
            n_err++; $display("FAIL vbl_ack_coincident: got %b expected 110", m68k_ipl_n);
        end
        irq_ack_cs = 1'b1; cycle(); irq_ack_cs = 1'b0; vblank = 1'b0; cycle();
        n_vec++;
        if (m68k_ipl_n !== 3'b111) begin
            n_err++; $display("FAIL vbl_reack: got %b expected 111", m68k_ipl_n);
        end
    endtask

    task automatic test_z80_irq();
        z80_cen = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            cycle();
            n_vec++;
            if (z80_int_n !== ((i < DIV) ? 1'b1 : 1'b0)) begin
                n_err++; $display("FAIL z80_int_enable%0d: got %b expected %b", i, z80_int_n, (i < DIV));
            end
        end
        M1_n = 1'b0; IORQ_n = 1'b0; cycle();
        M1_n = 1'b1; IORQ_n = 1'b1; cycle();
        n_vec++;
        if (z80_int_n !== 1'b1) begin
            n_err++; $display("FAIL z80_ack: got %b expected 1", z80_int_n);
        end
        for (int i = 35; i <= 40; i++) begin
            cycle();
            n_vec++;
            if (z80_int_n !== ((i < 40) ? 1'b1 : 1'b0)) begin
                n_err++; $display("FAIL z80_rewrap%0d: got %b expected %b", i, z80_int_n, (i < 40));
            end
        end
        z80_cen = 1'b0;
        M1_n = 1'b0; IORQ_n = 1'b0; cycle();
        M1_n = 1'b1; IORQ_n = 1'b1; cycle();
        n_vec++;
        if (z80_int_n !== 1'b1) begin
            n_err++; $display("FAIL z80_final_ack: got %b expected 1", z80_int_n);
        end
    endtask

`ifdef SND_LATCH_FIFO_EN
    task automatic test_fifo_fill();
        logic [7:0] want;
        for (int k = 1; k <= 5; k++) m68k_write(8'(k));
        n_vec++;
        if (latch_full !== 1'b1 || z80_din !== 8'h01) begin
            n_err++; $display("FAIL fifo_full: got full=%b din=%h expected 1 01", latch_full, z80_din);
        end
        for (int k = 1; k <= 4; k++) begin
            want = 8'(k);
            n_vec++;
            if (z80_din !== want) begin
                n_err++; $display("FAIL fifo_read%0d: got %h expected %h", k, z80_din, want);
            end
            z80_pulse(1'b1, 1'b0);
        end
        n_vec++;
        if (z80_din !== 8'h00 || latch_full !== 1'b0) begin
            n_err++; $display("FAIL fifo_drained: got din=%h full=%b expected 00 0", z80_din, latch_full);
        end
    endtask

    task automatic test_fifo_write_clear();
        m68k_write(8'h11); m68k_write(8'h22); m68k_write(8'h33);
        sound_latch_cs = 1'b1; m68k_rw = 1'b0; m68k_lds_n = 1'b0; m68k_dout = 8'h77;
        z80_latch_clr_cs = 1'b1;
        cycle();
        sound_latch_cs = 1'b0; m68k_rw = 1'b1; m68k_lds_n = 1'b1; z80_latch_clr_cs = 1'b0;
        cycle();
        n_vec++;
        if (z80_din !== 8'h77 || latch_full !== 1'b0) begin
            n_err++; $display("FAIL fifo_wc_head: got din=%h full=%b expected 77 0", z80_din, latch_full);
        end
        z80_pulse(1'b1, 1'b0);
        n_vec++;
        if (z80_din !== 8'h00) begin
            n_err++; $display("FAIL fifo_wc_single: got %h expected 00", z80_din);
        end
    endtask
`endif

    task automatic test_async_reset();
        m68k_write(8'h3C);
        vblank = 1'b1; cycle(); cycle();
        sound_latch_cs = 1'b1; m68k_rw = 1'b0; m68k_lds_n = 1'b0; m68k_dout = 8'hC3;
        #2 reset = 1'b1;
        #1;
        model_clear();
        n_vec++;
        if (m68k_ipl_n !== 3'b111 || z80_int_n !== 1'b1 || z80_din !== 8'h00 || latch_full !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: got ipl=%b int_n=%b din=%h full=%b expected 111 1 00 0",
                     m68k_ipl_n, z80_int_n, z80_din, latch_full);
        end
        @(negedge clk_sys);
        cycle();
        reset = 1'b0;
        cycle(); cycle(); cycle();
        n_vec++;
        if (z80_din !== 8'h00 || latch_full !== 1'b0 || m68k_ipl_n !== 3'b111) begin
            n_err++;
            $display("FAIL held_select_after_reset: got din=%h full=%b ipl=%b expected 00 0 111",
                     z80_din, latch_full, m68k_ipl_n);
        end
        sound_latch_cs = 1'b0; m68k_rw = 1'b1; m68k_lds_n = 1'b1; vblank = 1'b0;
        cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            sound_latch_cs   = ($urandom_range(0, 3) == 0);
            m68k_rw          = ($urandom_range(0, 3) == 0);
            m68k_lds_n       = ($urandom_range(0, 4) == 0);
            m68k_dout        = 8'($urandom);
            irq_ack_cs       = ($urandom_range(0, 5) == 0);
            z80_latch_r_cs   = ($urandom_range(0, 3) == 0);
            z80_latch_clr_cs = ($urandom_range(0, 9) == 0);
            M1_n             = ($urandom_range(0, 2) != 0);
            IORQ_n           = ($urandom_range(0, 2) != 0);
            z80_cen          = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 11) == 0) vblank = ~vblank;
            cycle();
            n_vec++;
            if (m68k_ipl_n !== (m_vpend ? 3'b110 : 3'b111) || z80_int_n !== ~m_zpend ||
                z80_din !== exp_din() || latch_full !== exp_full()) begin
                n_err++;
                $display("FAIL random_cycle%0d: got ipl=%b int_n=%b din=%h full=%b expected %b %b %h %b",
                         i, m68k_ipl_n, z80_int_n, z80_din, latch_full,
                         (m_vpend ? 3'b110 : 3'b111), ~m_zpend, exp_din(), exp_full());
            end
        end
    endtask

    initial begin
        model_clear();
        @(negedge clk_sys);
        test_reset();
        test_latch();
        test_vblank();
        test_z80_irq();
`ifdef SND_LATCH_FIFO_EN
        test_fifo_fill();
        test_fifo_write_clear();
`endif
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
